// File: rtl/spi_pkg.sv
`default_nettype none
// ==== spi_pkg : shared SPI receiver constants and state encoding ==== rev 1.0 ====
package spi_pkg;
  localparam int SPI_BYTE_W     = 8;
  localparam int SPI_FIFO_DEPTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;
endpackage
`default_nettype wire

// File: rtl/spi_byte_fifo.sv
`default_nettype none
// ==== spi_byte_fifo : synchronous FIFO with registered first-word-fall-through head ==== rev 1.0 ====
module spi_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rdata;

  logic             w_pop, w_push, w_head_new;
  logic [AW-1:0]    w_rd_next;
  logic [AW:0]      w_count_next;

  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == (AW+1)'(DEPTH));
  assign w_pop        = i_pop && !o_empty;
  assign w_push       = i_push && (!o_full || w_pop);
  assign w_rd_next    = r_rd_ptr + AW'(w_pop);
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  // The written word becomes the head when nothing else will remain buffered.
  assign w_head_new   = w_push && (r_count == (AW+1)'(w_pop));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      r_count <= w_count_next;
      if (w_count_next != '0) r_rdata <= w_head_new ? i_wdata : r_mem[w_rd_next];
    end
  end

  assign o_rdata = r_rdata;
  assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ==== spi_rx_fifo : SPI mode-0 slave receiver with synchronizers and byte FIFO ==== rev 1.0 ====
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = SPI_FIFO_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic                          i_sclk,
  input  logic                          i_ss,
  input  logic                          i_mosi,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [SPI_BYTE_W-1:0]         o_data,
  output logic                          o_sof,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow,
  output logic                          o_frame_err
);
  localparam int BIT_CW = $clog2(SPI_BYTE_W);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync, r_sync_fill;
  logic                   r_sclk_d;
  logic                   w_sclk, w_ss, w_mosi, w_rise, w_sync_live;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sync_fill <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sync_fill <= {r_sync_fill[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise      = w_sclk && !r_sclk_d;
  // Reset-value ss highs are not real bus state; only arm on a genuine high.
  assign w_sync_live = r_sync_fill[SYNC_STAGES-1];

  rx_state_t               r_state;
  logic                    r_armed, r_first, r_frame_err, r_overflow;
  logic [SPI_BYTE_W-2:0]   r_shreg;
  logic [BIT_CW-1:0]       r_bitcnt;
  logic                    w_push, w_pop, w_empty, w_full;
  logic [SPI_BYTE_W:0]     w_wdata, w_rdata;

  assign w_push  = (r_state == SHIFT) && !w_ss && w_rise && (r_bitcnt == BIT_CW'(SPI_BYTE_W-1));
  assign w_wdata = {r_first, r_shreg, w_mosi};
  assign w_pop   = i_ready && !w_empty;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_armed     <= 1'b0;
      r_first     <= 1'b0;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_sync_live && w_ss) r_armed <= 1'b1;
      case (r_state)
        IDLE: begin
          if (r_armed && !w_ss) begin
            r_state <= SHIFT;
            r_first <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_ss) begin
            r_state     <= IDLE;
            r_bitcnt    <= '0;
            r_shreg     <= '0;
            r_frame_err <= (r_bitcnt != '0);
          end else if (w_rise) begin
            r_shreg  <= {r_shreg[SPI_BYTE_W-3:0], w_mosi};
            r_bitcnt <= r_bitcnt + BIT_CW'(1);
            if (w_push) r_first <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_overflow <= 1'b0;
    else          r_overflow <= w_push && w_full && !w_pop;
  end

  spi_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SPI_BYTE_W + 1)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_count)
  );

  assign o_valid     = !w_empty;
  assign o_sof       = w_rdata[SPI_BYTE_W];
  assign o_data      = w_rdata[SPI_BYTE_W-1:0];
  assign o_overflow  = r_overflow;
  assign o_frame_err = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_spi_rx_fifo.sv
`default_nettype none
// ==== tb_spi_rx_fifo : scoreboard bench for spi_rx_fifo ==== rev 1.0 ====
module tb_spi_rx_fifo;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_sclk = 1'b0, i_ss = 1'b1, i_mosi = 1'b0, i_ready = 1'b0;
  logic       o_valid, o_sof, o_overflow, o_frame_err;
  logic [7:0] o_data;
  logic [3:0] o_count;

  int tests = 0, fails = 0;
  int ovf_cnt = 0, ferr_cnt = 0, pop_cnt = 0;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  spi_rx_fifo #(.FIFO_DEPTH(8), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_sclk     (i_sclk),
    .i_ss       (i_ss),
    .i_mosi     (i_mosi),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_sof      (o_sof),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_frame_err(o_frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_overflow)  ovf_cnt++;
      if (o_frame_err) ferr_cnt++;
      if (o_valid && i_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got data 0x%0h sof %0b, expected no transfer", o_data, o_sof);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          check("pop_data", o_data, e[7:0]);
          check("pop_sof", o_sof, e[8]);
        end
      end
    end
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 i_ready = v;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) i_mosi = b;
    repeat (10) @(negedge clk);
    i_sclk = 1'b1;
    repeat (10) @(negedge clk);
    i_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic frame_start();
    @(negedge clk) i_ss = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (5) @(negedge clk);
    i_ss = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((o_count != 0 || sb.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_sb_left"}, sb.size(), 0);
    check({name, "_count"}, o_count, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       new_frame;
    logic       exp_sof;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf0, ferr0, pop0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 1'b0};
    vecs[5] = '{8'h7E, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_data", o_data, 0);
    check("rst_sof", o_sof, 0);
    check("rst_pulses", {o_overflow, o_frame_err}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Table-driven frames with the consumer always ready
    set_ready(1'b1);
    ovf0 = ovf_cnt; ferr0 = ferr_cnt;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].new_frame) begin
        if (i > 0) frame_end();
        frame_start();
      end
      sb.push_back({vecs[i].exp_sof, vecs[i].data});
      send_byte(vecs[i].data);
    end
    frame_end();
    wait_drain("table");
    check("table_no_ovf", ovf_cnt - ovf0, 0);
    check("table_no_ferr", ferr_cnt - ferr0, 0);

    // Overflow: nine bytes into an eight-deep buffer
    set_ready(1'b0);
    ovf0 = ovf_cnt; ferr0 = ferr_cnt;
    frame_start();
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) sb.push_back({(k == 1), 8'(k)});
      send_byte(8'(k));
      if (k == 8) begin
        check("ovf_before9", ovf_cnt - ovf0, 0);
        check("count_full", o_count, 8);
      end
    end
    check("ovf_at9", ovf_cnt - ovf0, 1);
    check("count_after9", o_count, 8);
    check("hold_valid", o_valid, 1);
    check("hold_data", o_data, 8'h01);
    repeat (5) @(negedge clk);
    check("hold_data_later", {o_sof, o_data}, 9'h101);
    frame_end();
    check("ovf_no_ferr", ferr_cnt - ferr0, 0);
    set_ready(1'b1);
    wait_drain("ovf_drain");

    // Partial byte then ss rise
    ferr0 = ferr_cnt;
    frame_start();
    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    frame_end();
    check("ferr_pulse", ferr_cnt - ferr0, 1);
    check("ferr_count", o_count, 0);
    frame_start();
    sb.push_back({1'b1, 8'hFF});
    send_byte(8'hFF);
    frame_end();
    wait_drain("ferr_next");

    // Full buffer, pop in the same cycle as the 0x77 push
    set_ready(1'b0);
    ovf0 = ovf_cnt;
    frame_start();
    for (int k = 0; k < 8; k++) begin
      sb.push_back({(k == 0), 8'h10 + 8'(k)});
      send_byte(8'h10 + 8'(k));
    end
    check("simul_full", o_count, 8);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h77 >> i));
    sb.push_back({1'b0, 8'h77});
    @(negedge clk) i_mosi = 1'b1;
    repeat (10) @(negedge clk);
    i_sclk = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk);
    #1 i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
    repeat (9) @(negedge clk);
    i_sclk = 1'b0;
    repeat (5) @(negedge clk);
    check("simul_no_ovf", ovf_cnt - ovf0, 0);
    check("simul_count", o_count, 8);
    frame_end();
    set_ready(1'b1);
    wait_drain("simul_drain");

    // Reset mid-byte with ss held low
    frame_start();
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_count", o_count, 0);
    rst_n = 1'b1;
    ferr0 = ferr_cnt; pop0 = pop_cnt;
    for (int i = 11; i >= 0; i--) send_bit(1'(12'hABC >> i));
    repeat (5) @(negedge clk);
    check("post_rst_count", o_count, 0);
    check("post_rst_pops", pop_cnt - pop0, 0);
    frame_end();
    check("post_rst_ferr", ferr_cnt - ferr0, 0);
    frame_start();
    sb.push_back({1'b1, 8'h5A});
    send_byte(8'h5A);
    frame_end();
    wait_drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
